// File: rtl/timer_input_entry.sv
`default_nettype none
// ============================================================================
// Module      : timer_input_entry
// Description : Keypad cook-time entry. Synchronises and debounces a one-hot
//               decimal keypad and shifts each new digit into an M:SS BCD time.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_input_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enablen,
    input  logic [9:0] switches,
    output logic [3:0] units_of_seconds,
    output logic [3:0] tens_of_seconds,
    output logic [3:0] units_of_minutes,
    output logic       loadn
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [0:0] c_idle    = 1'b0;
    localparam logic [0:0] c_pressed = 1'b1;

    logic [9:0]         r_sync1;
    logic [9:0]         r_sync2;
    logic [9:0]         r_cand;
    logic [c_cnt_w-1:0] r_cnt;
    logic [9:0]         r_debounced;
    logic [0:0]         r_state;
    logic [3:0]         r_sec_units;
    logic [3:0]         r_sec_tens;
    logic [3:0]         r_min_units;
    logic               r_loadn;

    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_onehot;
    logic               w_released;
    logic [3:0]         w_code;
    logic               w_accept;

    // r_cnt counts consecutive identical synchronised samples, saturating at the threshold
    always_comb begin
        if (r_sync2 != r_cand) begin
            w_cnt_next = c_cnt_one;
        end else if (r_cnt == c_cnt_max) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + c_cnt_one;
        end
    end

    always_comb begin
        w_code = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_debounced[k]) begin
                w_code = 4'(k);
            end
        end
        w_released = (r_debounced == 10'd0);
        w_onehot   = !w_released && ((r_debounced & (r_debounced - 10'd1)) == 10'd0);
        w_accept   = (r_state == c_idle) && w_onehot && enablen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 10'd0;
            r_sync2     <= 10'd0;
            r_cand      <= 10'd0;
            r_cnt       <= '0;
            r_debounced <= 10'd0;
            r_state     <= c_idle;
            r_sec_units <= 4'd0;
            r_sec_tens  <= 4'd0;
            r_min_units <= 4'd0;
            r_loadn     <= 1'b1;
        end else begin
            r_sync1 <= switches;
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == c_cnt_max) begin
                r_debounced <= r_sync2;
            end

            // FSM tracks keys even while disabled so a held key is never accepted late
            case (r_state)
                c_idle:    if (w_onehot)   r_state <= c_pressed;
                c_pressed: if (w_released) r_state <= c_idle;
                default:   r_state <= c_idle;
            endcase

            if (!enablen) begin
                r_sec_units <= 4'd0;
                r_sec_tens  <= 4'd0;
                r_min_units <= 4'd0;
                r_loadn     <= 1'b1;
            end else if (w_accept) begin
                r_min_units <= r_sec_tens;
                r_sec_tens  <= r_sec_units;
                r_sec_units <= w_code;
                r_loadn     <= 1'b0;
            end else begin
                r_loadn     <= 1'b1;
            end
        end
    end

    assign units_of_seconds = r_sec_units;
    assign tens_of_seconds  = r_sec_tens;
    assign units_of_minutes = r_min_units;
    assign loadn            = r_loadn;

endmodule
`default_nettype wire

// File: tb/tb_timer_input_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_input_entry
// Description : Directed self-checking bench for timer_input_entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_input_entry;

    logic       clk;
    logic       rst;
    logic       enablen;
    logic [9:0] switches;
    logic [3:0] units_of_seconds;
    logic [3:0] tens_of_seconds;
    logic [3:0] units_of_minutes;
    logic       loadn;

    int n_cmp;
    int n_bad;
    int pulses;
    int base;

    timer_input_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .enablen          (enablen),
        .switches         (switches),
        .units_of_seconds (units_of_seconds),
        .tens_of_seconds  (tens_of_seconds),
        .units_of_minutes (units_of_minutes),
        .loadn            (loadn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (loadn === 1'b0) pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [9:0] v);
        switches = v;
        tick(12);
    endtask

    task automatic test_reset();
        rst = 1'b1; enablen = 1'b0; switches = 10'd0;
        tick(3);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds, loadn} !== 13'h0001) begin
            n_bad++;
            $display("FAIL reset_state: got M/T/S/loadn=%h/%h/%h/%b want 0/0/0/1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, loadn);
        end
        base = pulses;
        rst = 1'b0;
        tick(5);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h000 || pulses != base) begin
            n_bad++;
            $display("FAIL post_reset_disabled: got %h%h%h pulses=%0d want 000 pulses=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
    endtask

    task automatic test_shift_in();
        enablen = 1'b1;
        tick(2);
        base = pulses;
        key(10'b01_0000_0000);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h008 || pulses - base != 1) begin
            n_bad++;
            $display("FAIL press_8: got %h%h%h pulses=%0d want 008 pulses=1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'd0);
        base = pulses;
        key(10'b00_0000_0001);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h080 || pulses - base != 1) begin
            n_bad++;
            $display("FAIL press_0: got %h%h%h pulses=%0d want 080 pulses=1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'd0);
        base = pulses;
        key(10'b00_1000_0000);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h807 || pulses - base != 1) begin
            n_bad++;
            $display("FAIL press_7: got %h%h%h pulses=%0d want 807 pulses=1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
    endtask

    task automatic test_hold();
        // bit7 is still held from the previous scenario
        base = pulses;
        tick(100);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h807 || pulses != base) begin
            n_bad++;
            $display("FAIL hold_continued: got %h%h%h pulses=%0d want 807 pulses=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'd0);
        base = pulses;
        switches = 10'b00_1000_0000;
        tick(100);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h077 || pulses - base != 1) begin
            n_bad++;
            $display("FAIL hold_fresh: got %h%h%h pulses=%0d want 077 pulses=1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'd0);
    endtask

    task automatic test_back_to_back();
        base = pulses;
        for (int d = 1; d <= 4; d++) begin
            key(10'(1 << d));
            key(10'd0);
        end
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h234 || pulses - base != 4) begin
            n_bad++;
            $display("FAIL four_presses: got %h%h%h pulses=%0d want 234 pulses=4",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
    endtask

    task automatic test_latency();
        switches = 10'b00_0010_0000;
        tick(6);
        n_cmp++;
        if (units_of_seconds !== 4'd4 || loadn !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_early: got S=%h loadn=%b want S=4 loadn=1", units_of_seconds, loadn);
        end
        tick(1);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h345 || loadn !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_edge: got %h%h%h loadn=%b want 345 loadn=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, loadn);
        end
        tick(1);
        n_cmp++;
        if (loadn !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_pulse_width: got loadn=%b want 1", loadn);
        end
        key(10'd0);
    endtask

    task automatic test_enable();
        base = pulses;
        enablen = 1'b0;
        key(10'b00_0100_0000);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h000 || pulses != base) begin
            n_bad++;
            $display("FAIL disabled_clear: got %h%h%h pulses=%0d want 000 pulses=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        enablen = 1'b1;
        tick(20);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h000 || pulses != base) begin
            n_bad++;
            $display("FAIL held_through_enable: got %h%h%h pulses=%0d want 000 pulses=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'd0);
        key(10'b00_0100_0000);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h006 || pulses - base != 1) begin
            n_bad++;
            $display("FAIL repress_6: got %h%h%h pulses=%0d want 006 pulses=1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'd0);
        base = pulses;
        key(10'b00_0010_0100);
        key(10'd0);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h006 || pulses != base) begin
            n_bad++;
            $display("FAIL two_keys: got %h%h%h pulses=%0d want 006 pulses=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
    endtask

    task automatic test_glitch_and_reset();
        base = pulses;
        switches = 10'b00_0000_1000;
        tick(3);
        switches = 10'd0;
        tick(12);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h006 || pulses != base) begin
            n_bad++;
            $display("FAIL glitch_3: got %h%h%h pulses=%0d want 006 pulses=0",
                     units_of_minutes, tens_of_seconds, units_of_seconds, pulses - base);
        end
        key(10'b10_0000_0000);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds} !== 12'h069) begin
            n_bad++;
            $display("FAIL press_9: got %h%h%h want 069",
                     units_of_minutes, tens_of_seconds, units_of_seconds);
        end
        rst = 1'b1;
        switches = 10'd0;
        tick(1);
        n_cmp++;
        if ({units_of_minutes, tens_of_seconds, units_of_seconds, loadn} !== 13'h0001) begin
            n_bad++;
            $display("FAIL mid_entry_reset: got %h%h%h loadn=%b want 000 loadn=1",
                     units_of_minutes, tens_of_seconds, units_of_seconds, loadn);
        end
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; pulses = 0; base = 0;
        rst = 1'b1; enablen = 1'b0; switches = 10'd0;
        test_reset();
        test_shift_in();
        test_hold();
        test_back_to_back();
        test_latency();
        test_enable();
        test_glitch_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
